beep_note_sched: RTL and testbench
==================================

# beep_note_sched

Note scheduler and arbiter for the single-buzzer PWM tone generator. It accepts note commands (period, duration) from two requesters over valid/ready: port A is high priority (alarm or key-click) and port B is low priority (song player). It grants one requester at a time, times the note duration, inserts a silent articulation gap, and drives the period word that the tone generator consumes as its `pre_set`. The generator keeps its own 50 % duty PWM counter; this block only decides what plays and when.

## Interface
- `PERIOD_W`, 17: width of the tone period in clk cycles (the tone generator's `pre_set` width).
- `DUR_W`, 8: width of the note duration field, in ticks.
- `TICK_DIV`, 50000: clk cycles per duration tick (1 ms at 50 MHz); must be ≥ 2.
- `GAP_TICKS`, 10: silent ticks inserted after every completed note; 0 means no gap.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `a_valid` in 1: port A command valid.
- `a_period` in PERIOD_W: port A tone period; 0 means rest.
- `a_dur` in DUR_W: port A duration in ticks; 0 is treated as 1.
- `a_ready` out 1: port A accepted when `a_valid && a_ready`.
- `b_valid`, `b_period`, `b_dur`, `b_ready`: the same signals for port B.
- `preempt_en` in 1: allow a pending A command to abort a playing B note.
- `tone_period` out PERIOD_W: registered period to the tone generator; 0 means silent.
- `tone_on` out 1: high while a non-zero period is playing.
- `busy` out 1: state ≠ IDLE.
- `note_done` out 1: one-cycle pulse when a note's duration expires.
- `note_abort` out 1: one-cycle pulse when a B note is preempted.
- `done_src` out 1: source of the last finished or aborted note (0 = A, 1 = B); valid alongside either pulse.

## Operation
- FSM states: IDLE, PLAY, GAP.
- **IDLE**
  - `a_ready = 1`.
  - `b_ready = !a_valid`. Both ready signals are combinational from the state and `a_valid`.
  - On a transfer, latch the period, the duration (0 becomes 1) and the source; go to PLAY.
- **PLAY**
  - `tone_period` = latched period.
  - `tone_on` = (period ≠ 0).
  - The tick prescaler restarts at note start. The duration counter decrements on each tick.
  - On the last tick: pulse `note_done`, then go to GAP, or to IDLE if `GAP_TICKS` = 0.
- **GAP**
  - `tone_period` = 0.
  - Lasts `GAP_TICKS` ticks with the prescaler restarted, then go to IDLE.
  - No request is accepted during GAP.
- **Preemption**
  - Condition: in PLAY, source = B, `a_valid`, and `preempt_en`.
  - Pulse `note_abort` with `done_src` = 1, go straight to IDLE with no gap, and force `tone_period` to 0.
  - A is accepted in the following cycle.
- A never preempts A. B never preempts anything.
- Both ports valid in IDLE: A wins. B holds its request, and its data must stay stable until accepted.

## Timing
- Reset values:
  - state IDLE;
  - `tone_period` 0, `tone_on` 0, `busy` 0;
  - `note_done` 0, `note_abort` 0, `done_src` 0;
  - all counters 0.
- Since the FSM resets to IDLE, `a_ready` is 1 and `b_ready` is `!a_valid` immediately after reset.
- Transfer at the cycle-T edge:
  - `tone_period`, `tone_on` and `busy` take their values at T+1.
  - PLAY lasts exactly dur × `TICK_DIV` cycles.
  - `note_done` is high during the last PLAY cycle.
- GAP lasts exactly `GAP_TICKS` × `TICK_DIV` cycles. The earliest next acceptance is the first IDLE cycle after that.
- Back-to-back notes with `GAP_TICKS` = 0: one IDLE cycle separates notes, with `tone_period` = 0 for that cycle.
- Preemption:
  - Detected in cycle P: `note_abort` is high in cycle P.
  - IDLE at P+1, with `a_ready` = 1.
  - The A note's `tone_period` appears at P+2.
- Reset mid-note: `tone_period` is 0 on assertion, asynchronously. No pulses are generated and the pending command is lost.
- Counter widths:
  - tick counter: ceil(log2(`TICK_DIV`));
  - duration counter: `DUR_W`;
  - gap counter: wide enough for `GAP_TICKS`.
- No counter may wrap during normal operation.

## Structure
- Package `beep_pkg`:
  - `PERIOD_W`;
  - note period constants: M1..M7 including sharps, H1..H7, HH1, HH2, D5..D7, rest S;
  - the state enum.
- Sub-module `beep_tick_gen`: prescaler with a synchronous `restart` input and a one-cycle `tick` output every `TICK_DIV` cycles.
- The FSM, arbitration and output registers live in `beep_note_sched`.

## Test plan
Bench uses `TICK_DIV` = 4 and `GAP_TICKS` = 2.
- **Single note:** B sends period 47801, dur 3. Required:
  - `tone_period` = 47801 for exactly 12 cycles;
  - `note_done` with `done_src` = 1 on the 12th of those cycles;
  - `tone_period` = 0 for 8 cycles;
  - then IDLE.
- **Simultaneous requests:** A (95602, 1) and B (63775, 2) both valid in IDLE. Required:
  - A plays first and `b_ready` stays 0;
  - B plays after A's gap and is accepted on the first IDLE cycle.
- **Preemption:** B playing (31888, 10) with `preempt_en` = 1; A (23883, 1) arrives at tick 2. Required:
  - `note_abort` pulses;
  - 23883 appears 2 cycles later;
  - there is no gap before A's note.
- **Preemption disabled:** same stimulus with `preempt_en` = 0. Required: B completes all 40 cycles, and A starts after B's gap.
- **Rest and zero duration:** period 0, dur 0. Required: `tone_on` stays 0 for 4 cycles, then `note_done` pulses.
- **Reset mid-note:** assert `rst` during PLAY. Required: `tone_period` is 0 immediately; after release the FSM is in IDLE with `a_ready` = 1.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared constants for the buzzer note scheduler: period width, note period table, FSM states.
package beep_pkg;

  localparam int PERIOD_W = 17;

  // Half-period-free tone periods in 50 MHz clk cycles; D* low, M* middle, H*/HH* high octaves.
  localparam logic [PERIOD_W-1:0] S    = 17'd0;
  localparam logic [PERIOD_W-1:0] D5   = 17'd127551;
  localparam logic [PERIOD_W-1:0] D6   = 17'd113636;
  localparam logic [PERIOD_W-1:0] D7   = 17'd101239;
  localparam logic [PERIOD_W-1:0] M1   = 17'd95602;
  localparam logic [PERIOD_W-1:0] M1S  = 17'd90252;
  localparam logic [PERIOD_W-1:0] M2   = 17'd85178;
  localparam logic [PERIOD_W-1:0] M2S  = 17'd80386;
  localparam logic [PERIOD_W-1:0] M3   = 17'd75872;
  localparam logic [PERIOD_W-1:0] M4   = 17'd71633;
  localparam logic [PERIOD_W-1:0] M4S  = 17'd67567;
  localparam logic [PERIOD_W-1:0] M5   = 17'd63775;
  localparam logic [PERIOD_W-1:0] M5S  = 17'd60168;
  localparam logic [PERIOD_W-1:0] M6   = 17'd56818;
  localparam logic [PERIOD_W-1:0] M6S  = 17'd53648;
  localparam logic [PERIOD_W-1:0] M7   = 17'd50607;
  localparam logic [PERIOD_W-1:0] H1   = 17'd47801;
  localparam logic [PERIOD_W-1:0] H2   = 17'd42589;
  localparam logic [PERIOD_W-1:0] H3   = 17'd37936;
  localparam logic [PERIOD_W-1:0] H4   = 17'd35791;
  localparam logic [PERIOD_W-1:0] H5   = 17'd31888;
  localparam logic [PERIOD_W-1:0] H6   = 17'd28409;
  localparam logic [PERIOD_W-1:0] H7   = 17'd25303;
  localparam logic [PERIOD_W-1:0] HH1  = 17'd23883;
  localparam logic [PERIOD_W-1:0] HH2  = 17'd21283;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_t;

endpackage

// File: rtl/beep_tick_gen.sv
// Duration-tick prescaler: one-cycle tick every TICK_DIV clk cycles, realigned by restart.
module beep_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // restart makes the following cycle count zero, so the first tick lands TICK_DIV cycles later
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/beep_note_sched.sv
// Two-port note arbiter/timer for the buzzer tone generator: A has priority and may preempt B.
module beep_note_sched #(
  parameter int PERIOD_W  = beep_pkg::PERIOD_W,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic [PERIOD_W-1:0] a_period,
  input  logic [DUR_W-1:0]    a_dur,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [PERIOD_W-1:0] b_period,
  input  logic [DUR_W-1:0]    b_dur,
  output logic                b_ready,
  input  logic                preempt_en,
  output logic [PERIOD_W-1:0] tone_period,
  output logic                tone_on,
  output logic                busy,
  output logic                note_done,
  output logic                note_abort,
  output logic                done_src
);
  import beep_pkg::*;

  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_TICKS);

  state_t              state_q;
  logic [PERIOD_W-1:0] tone_q;
  logic                tone_on_q;
  logic [DUR_W-1:0]    dur_q;
  logic [GAP_W-1:0]    gap_q;
  logic                src_q;
  logic                last_src_q;

  logic                tick, restart, acc_a, acc_b, abort, last_tick;
  logic [PERIOD_W-1:0] sel_period;
  logic [DUR_W-1:0]    sel_dur;

  beep_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    a_ready    = (state_q == ST_IDLE);
    b_ready    = (state_q == ST_IDLE) && !a_valid;
    acc_a      = a_ready && a_valid;
    acc_b      = b_ready && b_valid;
    sel_period = acc_a ? a_period : b_period;
    sel_dur    = acc_a ? a_dur : b_dur;
    abort      = (state_q == ST_PLAY) && src_q && a_valid && preempt_en;
    // an abort wins over a coincident expiry so A is not delayed by a gap
    last_tick  = (state_q == ST_PLAY) && tick && (dur_q == DUR_W'(1)) && !abort;
    restart    = acc_a || acc_b || last_tick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tone_q     <= '0;
      tone_on_q  <= 1'b0;
      dur_q      <= '0;
      gap_q      <= '0;
      src_q      <= 1'b0;
      last_src_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_a || acc_b) begin
            tone_q    <= sel_period;
            tone_on_q <= (sel_period != '0);
            dur_q     <= (sel_dur == '0) ? DUR_W'(1) : sel_dur;
            src_q     <= acc_b;
            state_q   <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (abort) begin
            tone_q     <= '0;
            tone_on_q  <= 1'b0;
            dur_q      <= '0;
            last_src_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (last_tick) begin
            tone_q     <= '0;
            tone_on_q  <= 1'b0;
            dur_q      <= '0;
            last_src_q <= src_q;
            if (GAP_TICKS == 0) begin
              state_q <= ST_IDLE;
            end else begin
              gap_q   <= GAP_INIT;
              state_q <= ST_GAP;
            end
          end else if (tick) begin
            dur_q <= dur_q - 1'b1;
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_q <= GAP_W'(1)) begin
              gap_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tone_period = tone_q;
  assign tone_on     = tone_on_q;
  assign busy        = (state_q != ST_IDLE);
  assign note_done   = last_tick;
  assign note_abort  = abort;
  assign done_src    = last_tick ? src_q : (abort ? 1'b1 : last_src_q);

endmodule

// File: tb/tb_beep_note_sched.sv
// Directed bench for beep_note_sched with TICK_DIV = 4 and GAP_TICKS = 2.
module tb_beep_note_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, preempt_en;
  logic [16:0] a_period, b_period;
  logic [7:0]  a_dur, b_dur;
  logic        a_ready, b_ready;
  logic [16:0] tone_period;
  logic        tone_on, busy, note_done, note_abort, done_src;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  beep_note_sched #(
    .PERIOD_W (17),
    .DUR_W    (8),
    .TICK_DIV (4),
    .GAP_TICKS(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_period   (a_period),
    .a_dur      (a_dur),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_period   (b_period),
    .b_dur      (b_dur),
    .b_ready    (b_ready),
    .preempt_en (preempt_en),
    .tone_period(tone_period),
    .tone_on    (tone_on),
    .busy       (busy),
    .note_done  (note_done),
    .note_abort (note_abort),
    .done_src   (done_src)
  );

  // Each step lands 2 time units after a rising edge, i.e. inside the next cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (tone_period !== 17'd0 || tone_on !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_outputs: tone_period=%0d tone_on=%b busy=%b, want 0/0/0", tone_period, tone_on, busy);
    else passes++;
    checks++;
    if (note_done !== 1'b0 || note_abort !== 1'b0 || done_src !== 1'b0)
      $display("FAIL reset_pulses: done=%b abort=%b src=%b, want 0/0/0", note_done, note_abort, done_src);
    else passes++;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1)
      $display("FAIL reset_ready: a_ready=%b b_ready=%b, want 1/1", a_ready, b_ready);
    else passes++;
    a_valid = 1'b1;
    #1;
    checks++;
    if (b_ready !== 1'b0)
      $display("FAIL reset_b_ready_masked: b_ready=%b, want 0", b_ready);
    else passes++;
    a_valid = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || a_ready !== 1'b1)
      $display("FAIL reset_release: busy=%b a_ready=%b, want 0/1", busy, a_ready);
    else passes++;
  endtask

  task automatic test_single_note();
    b_period = 17'd47801; b_dur = 8'd3; b_valid = 1'b1;
    #1;
    checks++;
    if (b_ready !== 1'b1) $display("FAIL single_b_ready: got %b want 1", b_ready);
    else passes++;
    step();
    b_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (tone_period !== 17'd47801 || tone_on !== 1'b1 || busy !== 1'b1)
        $display("FAIL single_play cyc%0d: tone=%0d on=%b busy=%b, want 47801/1/1", i, tone_period, tone_on, busy);
      else passes++;
      checks++;
      if (note_done !== (i == 11))
        $display("FAIL single_done cyc%0d: note_done=%b want %b", i, note_done, (i == 11));
      else passes++;
      if (i == 11) begin
        checks++;
        if (done_src !== 1'b1) $display("FAIL single_done_src: got %b want 1", done_src);
        else passes++;
      end
      step();
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tone_period !== 17'd0 || busy !== 1'b1 || a_ready !== 1'b0 || note_done !== 1'b0)
        $display("FAIL single_gap cyc%0d: tone=%0d busy=%b a_ready=%b done=%b, want 0/1/0/0",
                 i, tone_period, busy, a_ready, note_done);
      else passes++;
      step();
    end
    checks++;
    if (busy !== 1'b0 || a_ready !== 1'b1)
      $display("FAIL single_idle: busy=%b a_ready=%b, want 0/1", busy, a_ready);
    else passes++;
  endtask

  task automatic test_simultaneous();
    a_period = 17'd95602; a_dur = 8'd1; a_valid = 1'b1;
    b_period = 17'd63775; b_dur = 8'd2; b_valid = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0)
      $display("FAIL simul_arb: a_ready=%b b_ready=%b, want 1/0", a_ready, b_ready);
    else passes++;
    step();
    a_valid = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (b_ready !== 1'b0 || tone_period !== ((i < 4) ? 17'd95602 : 17'd0))
        $display("FAIL simul_a_phase cyc%0d: b_ready=%b tone=%0d, want 0/%0d",
                 i, b_ready, tone_period, (i < 4) ? 95602 : 0);
      else passes++;
      if (i == 3) begin
        checks++;
        if (note_done !== 1'b1 || done_src !== 1'b0)
          $display("FAIL simul_a_done: done=%b src=%b, want 1/0", note_done, done_src);
        else passes++;
      end
      step();
    end
    checks++;
    if (b_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL simul_b_accept: b_ready=%b busy=%b, want 1/0", b_ready, busy);
    else passes++;
    step();
    b_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tone_period !== 17'd63775 || note_done !== (i == 7))
        $display("FAIL simul_b_play cyc%0d: tone=%0d done=%b, want 63775/%b", i, tone_period, note_done, (i == 7));
      else passes++;
      if (i == 7) begin
        checks++;
        if (done_src !== 1'b1) $display("FAIL simul_b_src: got %b want 1", done_src);
        else passes++;
      end
      step();
    end
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (busy !== 1'b0) $display("FAIL simul_end_idle: busy=%b want 0", busy);
    else passes++;
  endtask

  task automatic test_preempt(input logic en);
    preempt_en = en;
    b_period = 17'd31888; b_dur = 8'd10; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tone_period !== 17'd31888)
        $display("FAIL preempt%0d_b_early cyc%0d: tone=%0d want 31888", en, i, tone_period);
      else passes++;
      step();
    end
    // two ticks of B have elapsed; A arrives now
    a_period = 17'd23883; a_dur = 8'd1; a_valid = 1'b1;
    #1;
    if (en) begin
      checks++;
      if (note_abort !== 1'b1 || done_src !== 1'b1 || note_done !== 1'b0)
        $display("FAIL preempt_abort: abort=%b src=%b done=%b, want 1/1/0", note_abort, done_src, note_done);
      else passes++;
      step();
      checks++;
      if (busy !== 1'b0 || a_ready !== 1'b1 || tone_period !== 17'd0 || note_abort !== 1'b0)
        $display("FAIL preempt_idle: busy=%b a_ready=%b tone=%0d abort=%b, want 0/1/0/0",
                 busy, a_ready, tone_period, note_abort);
      else passes++;
      step();
      a_valid = 1'b0;
      checks++;
      if (tone_period !== 17'd23883 || tone_on !== 1'b1)
        $display("FAIL preempt_a_start: tone=%0d on=%b, want 23883/1", tone_period, tone_on);
      else passes++;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (note_done !== (i == 3) || (i == 3 && done_src !== 1'b0))
          $display("FAIL preempt_a_done cyc%0d: done=%b src=%b, want %b/0", i, note_done, done_src, (i == 3));
        else passes++;
        step();
      end
      for (int i = 0; i < 8; i++) step();
    end else begin
      for (int i = 9; i <= 40; i++) begin
        checks++;
        if (tone_period !== 17'd31888 || a_ready !== 1'b0 || note_abort !== 1'b0 || note_done !== (i == 40))
          $display("FAIL nopreempt_b cyc%0d: tone=%0d a_ready=%b abort=%b done=%b, want 31888/0/0/%b",
                   i, tone_period, a_ready, note_abort, note_done, (i == 40));
        else passes++;
        step();
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (tone_period !== 17'd0 || a_ready !== 1'b0)
          $display("FAIL nopreempt_gap cyc%0d: tone=%0d a_ready=%b, want 0/0", i, tone_period, a_ready);
        else passes++;
        step();
      end
      checks++;
      if (a_ready !== 1'b1 || busy !== 1'b0)
        $display("FAIL nopreempt_a_accept: a_ready=%b busy=%b, want 1/0", a_ready, busy);
      else passes++;
      step();
      a_valid = 1'b0;
      checks++;
      if (tone_period !== 17'd23883)
        $display("FAIL nopreempt_a_start: tone=%0d want 23883", tone_period);
      else passes++;
      for (int i = 0; i < 12; i++) step();
    end
    preempt_en = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL preempt%0d_end_idle: busy=%b want 0", en, busy);
    else passes++;
  endtask

  task automatic test_rest_zero_dur();
    a_period = 17'd0; a_dur = 8'd0; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tone_on !== 1'b0 || tone_period !== 17'd0 || busy !== 1'b1 || note_done !== (i == 3))
        $display("FAIL rest cyc%0d: on=%b tone=%0d busy=%b done=%b, want 0/0/1/%b",
                 i, tone_on, tone_period, busy, note_done, (i == 3));
      else passes++;
      step();
    end
    checks++;
    if (busy !== 1'b1 || note_done !== 1'b0)
      $display("FAIL rest_gap: busy=%b done=%b, want 1/0", busy, note_done);
    else passes++;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (busy !== 1'b0) $display("FAIL rest_end_idle: busy=%b want 0", busy);
    else passes++;
  endtask

  task automatic test_reset_mid_note();
    b_period = 17'd47801; b_dur = 8'd3; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    step();
    step();
    checks++;
    if (tone_period !== 17'd47801) $display("FAIL midrst_playing: tone=%0d want 47801", tone_period);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (tone_period !== 17'd0 || tone_on !== 1'b0 || busy !== 1'b0 || note_done !== 1'b0 || note_abort !== 1'b0)
      $display("FAIL midrst_async: tone=%0d on=%b busy=%b done=%b abort=%b, want all 0",
               tone_period, tone_on, busy, note_done, note_abort);
    else passes++;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1 || busy !== 1'b0 || tone_period !== 17'd0)
      $display("FAIL midrst_idle: a_ready=%b b_ready=%b busy=%b tone=%0d, want 1/1/0/0",
               a_ready, b_ready, busy, tone_period);
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; preempt_en = 1'b0;
    a_period = '0; b_period = '0; a_dur = '0; b_dur = '0;
    test_reset();
    test_single_note();
    test_simultaneous();
    test_preempt(1'b1);
    test_preempt(1'b0);
    test_rest_zero_dur();
    test_reset_mid_note();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
